// File: rtl/training_ctrl.sv
// Link-training sequencer: drives preamble and detector phases, checks the
// detected clock divider against a window and retries or gives up.
module training_ctrl #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 1024,
    localparam int unsigned RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 train_req,
    input  logic                 abort,
    input  logic [DIV_WIDTH-1:0] div_min,
    input  logic [DIV_WIDTH-1:0] div_max,
    output logic                 pre_start,
    input  logic                 pre_done,
    output logic                 det_start,
    input  logic                 det_done,
    input  logic [DIV_WIDTH-1:0] det_clk_div,
    output logic [DIV_WIDTH-1:0] clk_div_out,
    output logic                 busy,
    output logic                 link_up,
    output logic                 fail,
    output logic [RETRY_W-1:0]   retry_cnt
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_DETECT,
        S_CHECK,
        S_LINKED,
        S_FAIL
    } state_e;

    state_e               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [DIV_WIDTH-1:0] cap_q, cap_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 pre_start_q, pre_start_d;
    logic                 det_start_q, det_start_d;
    logic                 busy_q, busy_d;
    logic                 link_q, link_d;
    logic                 fail_q, fail_d;
    logic                 req_prev_q;

    logic                 phase_expired;
    logic                 cap_in_range;
    logic                 att_fail;

    assign phase_expired = (timer_q == TMR_W'(TIMEOUT - 1));
    assign cap_in_range  = (cap_q >= div_min) && (cap_q <= div_max);

    // Next-state and registered-output decode; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        timer_d     = '0;
        retry_d     = retry_q;
        cap_d       = cap_q;
        div_d       = div_q;
        att_fail    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (train_req) begin
                        state_d = S_SEND;
                        retry_d = '0;
                    end
                end
                S_SEND: begin
                    if (pre_done) begin
                        state_d = S_DETECT;
                    end else if (phase_expired) begin
                        att_fail = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_DETECT: begin
                    if (det_done) begin
                        cap_d   = det_clk_div;
                        state_d = S_CHECK;
                    end else if (phase_expired) begin
                        att_fail = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (cap_in_range) begin
                        state_d = S_LINKED;
                        div_d   = cap_q;
                    end else begin
                        att_fail = 1'b1;
                    end
                end
                S_LINKED: begin
                    if (train_req && !req_prev_q) begin
                        state_d = S_SEND;
                        retry_d = '0;
                    end
                end
                S_FAIL: begin
                    if (!train_req) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (att_fail) begin
                if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = S_SEND;
                end else begin
                    state_d = S_FAIL;
                end
            end
        end

        // A failed SEND re-enters SEND, so entry is not just a state change.
        pre_start_d = (state_d == S_SEND) && ((state_q != S_SEND) || att_fail);
        det_start_d = (state_d == S_DETECT) && (state_q != S_DETECT);
        busy_d      = (state_d == S_SEND) || (state_d == S_DETECT) || (state_d == S_CHECK);
        link_d      = (state_d == S_LINKED);
        fail_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            retry_q     <= '0;
            cap_q       <= '0;
            div_q       <= '0;
            pre_start_q <= 1'b0;
            det_start_q <= 1'b0;
            busy_q      <= 1'b0;
            link_q      <= 1'b0;
            fail_q      <= 1'b0;
            req_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            cap_q       <= cap_d;
            div_q       <= div_d;
            pre_start_q <= pre_start_d;
            det_start_q <= det_start_d;
            busy_q      <= busy_d;
            link_q      <= link_d;
            fail_q      <= fail_d;
            req_prev_q  <= train_req;
        end
    end

    assign pre_start   = pre_start_q;
    assign det_start   = det_start_q;
    assign busy        = busy_q;
    assign link_up     = link_q;
    assign fail        = fail_q;
    assign retry_cnt   = retry_q;
    assign clk_div_out = div_q;

endmodule

// File: tb/tb_training_ctrl.sv
// Self-checking bench for training_ctrl: directed scenarios plus randomized
// training runs scored against an attempt-level outcome model.
module tb_training_ctrl;

    localparam int unsigned DW   = 8;
    localparam int unsigned MAXR = 3;
    localparam int unsigned TO   = 16;

    logic          clk;
    logic          rst_n;
    logic          train_req;
    logic          abort;
    logic          pre_done;
    logic          det_done;
    logic [DW-1:0] div_min;
    logic [DW-1:0] div_max;
    logic [DW-1:0] det_clk_div;

    logic          pre_start, det_start, busy, link_up, fail;
    logic [DW-1:0] clk_div_out;
    logic [1:0]    retry_cnt;

    logic          l_pre_start, l_det_start, l_busy, l_link_up, l_fail;
    logic [DW-1:0] l_clk_div_out;
    logic [1:0]    l_retry_cnt;

    int checks   = 0;
    int failures = 0;
    int n_pre    = 0;
    int dmin     = 4;
    int dmax     = 12;
    int a_ps[4];
    int a_dk[4];
    logic [DW-1:0] a_div[4];
    logic [DW-1:0] exp_div;

    training_ctrl #(.DIV_WIDTH(DW), .MAX_RETRY(MAXR), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .train_req(train_req), .abort(abort),
        .div_min(div_min), .div_max(div_max),
        .pre_start(pre_start), .pre_done(pre_done),
        .det_start(det_start), .det_done(det_done), .det_clk_div(det_clk_div),
        .clk_div_out(clk_div_out), .busy(busy), .link_up(link_up),
        .fail(fail), .retry_cnt(retry_cnt)
    );

    // Default 1024-cycle timeout, used for the long preamble scenario.
    training_ctrl #(.DIV_WIDTH(DW), .MAX_RETRY(MAXR)) u_dut_long (
        .clk(clk), .rst_n(rst_n), .train_req(train_req), .abort(abort),
        .div_min(div_min), .div_max(div_max),
        .pre_start(l_pre_start), .pre_done(pre_done),
        .det_start(l_det_start), .det_done(det_done), .det_clk_div(det_clk_div),
        .clk_div_out(l_clk_div_out), .busy(l_busy), .link_up(l_link_up),
        .fail(l_fail), .retry_cnt(l_retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pre_start === 1'b1) n_pre++;
    endtask

    task automatic set_range(input int lo, input int hi);
        dmin    = lo;
        dmax    = hi;
        div_min = DW'(lo);
        div_max = DW'(hi);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        exp_div = '0;
    endtask

    function automatic bit in_rng(input logic [DW-1:0] d);
        return (int'(d) >= dmin) && (int'(d) <= dmax);
    endfunction

    // An attempt succeeds iff both phases finish in time and the divider fits.
    function automatic bit att_ok(input int i);
        return (a_ps[i] != 0) && (a_dk[i] != 0) && in_rng(a_div[i]);
    endfunction

    // Drives one training run from IDLE; a latency of 0 means the done pulse never comes.
    task automatic run_training(input string tag);
        int            exp_idx = -1;
        int            pre0    = n_pre;
        logic [DW-1:0] div0    = exp_div;
        bit            linked  = 1'b0;
        for (int i = 0; i <= int'(MAXR); i++)
            if (exp_idx < 0 && att_ok(i)) exp_idx = i;

        train_req = 1'b1;
        tick();
        for (int i = 0; i <= int'(MAXR); i++) begin
            chk({tag, "_pre_start"}, pre_start, 1);
            chk({tag, "_retry_at_start"}, retry_cnt, i);
            if (a_ps[i] == 0) begin
                repeat (TO - 1) tick();
                chk({tag, "_send_last_cycle_busy"}, busy, 1);
                tick();
            end else begin
                repeat (a_ps[i] - 1) tick();
                pre_done = 1'b1;
                tick();
                pre_done = 1'b0;
                chk({tag, "_det_start"}, det_start, 1);
                if (a_dk[i] == 0) begin
                    repeat (TO - 1) tick();
                    chk({tag, "_det_last_cycle_start"}, det_start, 0);
                    tick();
                end else begin
                    repeat (a_dk[i] - 1) tick();
                    det_done    = 1'b1;
                    det_clk_div = a_div[i];
                    tick();
                    det_done    = 1'b0;
                    det_clk_div = DW'($urandom);
                    chk({tag, "_check_busy"}, busy, 1);
                    chk({tag, "_check_link"}, link_up, 0);
                    tick();
                    if (in_rng(a_div[i])) begin
                        chk({tag, "_linked_div"}, clk_div_out, a_div[i]);
                        exp_div = a_div[i];
                        linked  = 1'b1;
                    end
                end
            end
            if (linked) break;
        end

        chk({tag, "_out_link"}, link_up, exp_idx >= 0);
        chk({tag, "_out_fail"}, fail, exp_idx < 0);
        chk({tag, "_out_busy"}, busy, 0);
        chk({tag, "_out_retry"}, retry_cnt, (exp_idx >= 0) ? exp_idx : int'(MAXR));
        chk({tag, "_out_pre_pulses"}, n_pre - pre0, (exp_idx >= 0) ? exp_idx + 1 : int'(MAXR) + 1);
        chk({tag, "_out_div"}, clk_div_out, (exp_idx >= 0) ? a_div[exp_idx] : div0);
    endtask

    task automatic back_to_idle(input string tag);
        train_req = 1'b0;
        if (link_up === 1'b1) abort = 1'b1;
        tick();
        abort = 1'b0;
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_link"}, link_up, 0);
        chk({tag, "_idle_fail"}, fail, 0);
        chk({tag, "_idle_div_held"}, clk_div_out, exp_div);
    endtask

    initial begin
        int n_save;
        rst_n       = 1'b1;
        train_req   = 1'b0;
        abort       = 1'b0;
        pre_done    = 1'b0;
        det_done    = 1'b0;
        det_clk_div = '0;
        exp_div     = '0;
        set_range(4, 12);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pre_start", pre_start, 0);
        chk("rst_det_start", det_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_link", link_up, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_div", clk_div_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        n_pre = 0;

        repeat (5) tick();
        chk("idle_quiet_busy", busy, 0);
        chk("idle_quiet_pre", n_pre, 0);

        pre_done = 1'b1;
        det_done = 1'b1;
        tick();
        pre_done = 1'b0;
        det_done = 1'b0;
        tick();
        chk("stray_busy", busy, 0);
        chk("stray_det_start", det_start, 0);
        chk("stray_pre", n_pre, 0);

        train_req = 1'b1;
        abort     = 1'b1;
        tick();
        tick();
        chk("abort_prio_busy", busy, 0);
        chk("abort_prio_pre", n_pre, 0);
        train_req = 1'b0;
        abort     = 1'b0;
        tick();

        // Long preamble on the default-timeout instance.
        train_req = 1'b1;
        tick();
        chk("long_pre_start", l_pre_start, 1);
        tick();
        chk("long_pre_one_cycle", l_pre_start, 0);
        chk("long_send_busy", l_busy, 1);
        repeat (19) tick();
        pre_done = 1'b1;
        tick();
        pre_done = 1'b0;
        chk("long_det_start", l_det_start, 1);
        det_done    = 1'b1;
        det_clk_div = 8'd8;
        tick();
        det_done    = 1'b0;
        chk("long_check_busy", l_busy, 1);
        chk("long_check_link", l_link_up, 0);
        tick();
        chk("long_link", l_link_up, 1);
        chk("long_div", l_clk_div_out, 8);
        chk("long_retry", l_retry_cnt, 0);
        chk("long_linked_busy", l_busy, 0);
        train_req = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        chk("long_abort_link", l_link_up, 0);
        chk("long_abort_div", l_clk_div_out, 8);
        do_reset();

        // Every attempt detects an out-of-range divider.
        for (int i = 0; i < 4; i++) begin
            a_ps[i] = 3; a_dk[i] = 2; a_div[i] = 8'd20;
        end
        run_training("allbad");
        tick();
        chk("fail_hold", fail, 1);
        train_req = 1'b0;
        tick();
        chk("fail_release_fail", fail, 0);
        chk("fail_release_busy", busy, 0);
        n_save = n_pre;
        tick();
        chk("fail_release_no_pre", n_pre, n_save);

        // SEND timeout, then pre_done on the very last allowed cycle.
        a_ps[0] = 0;  a_dk[0] = 3; a_div[0] = 8'd7;
        a_ps[1] = TO; a_dk[1] = 5; a_div[1] = 8'd7;
        a_ps[2] = 1;  a_dk[2] = 1; a_div[2] = 8'd5;
        a_ps[3] = 1;  a_dk[3] = 1; a_div[3] = 8'd5;
        run_training("send_to");

        // Retrain from LINKED on a fresh rising edge of train_req.
        train_req = 1'b0;
        tick();
        chk("linked_hold", link_up, 1);
        train_req = 1'b1;
        tick();
        chk("retrain_link", link_up, 0);
        chk("retrain_pre", pre_start, 1);
        chk("retrain_busy", busy, 1);
        chk("retrain_retry", retry_cnt, 0);
        train_req = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        chk("retrain_abort_div", clk_div_out, exp_div);

        // DETECT timeout, then det_done on the last allowed cycle at the window edge.
        a_ps[0] = 2; a_dk[0] = 0;  a_div[0] = 8'd6;
        a_ps[1] = 4; a_dk[1] = TO; a_div[1] = 8'd12;
        run_training("det_to");
        back_to_idle("det_to");

        // Abort concurrent with det_done.
        train_req = 1'b1;
        tick();
        chk("abrt_pre", pre_start, 1);
        pre_done = 1'b1;
        tick();
        pre_done = 1'b0;
        chk("abrt_det_start", det_start, 1);
        det_done    = 1'b1;
        det_clk_div = 8'd9;
        abort       = 1'b1;
        train_req   = 1'b0;
        tick();
        det_done = 1'b0;
        abort    = 1'b0;
        chk("abrt_busy", busy, 0);
        chk("abrt_link", link_up, 0);
        chk("abrt_fail", fail, 0);
        chk("abrt_det_start_low", det_start, 0);
        chk("abrt_div", clk_div_out, exp_div);
        tick();
        chk("abrt_stays_idle", busy, 0);

        // Asynchronous reset in the middle of SEND.
        train_req = 1'b1;
        tick();
        tick();
        chk("rst_mid_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_pre", pre_start, 0);
        chk("rst_mid_retry", retry_cnt, 0);
        chk("rst_mid_div", clk_div_out, 0);
        chk("rst_mid_link", link_up, 0);
        train_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_div = '0;
        n_save  = n_pre;
        repeat (5) tick();
        chk("rst_rel_no_pre", n_pre, n_save);
        chk("rst_rel_busy", busy, 0);
        train_req = 1'b1;
        tick();
        chk("rst_rel_pre", pre_start, 1);
        train_req = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;

        // Randomized runs.
        for (int r = 0; r < 20; r++) begin
            int lo;
            lo = int'($urandom_range(0, 10));
            set_range(lo, lo + int'($urandom_range(0, 10)));
            for (int i = 0; i < 4; i++) begin
                int sel;
                sel     = int'($urandom_range(0, 5));
                a_ps[i] = (sel == 0) ? 0 : (sel == 1) ? int'(TO) : int'($urandom_range(1, TO));
                sel     = int'($urandom_range(0, 5));
                a_dk[i] = (sel == 0) ? 0 : (sel == 1) ? int'(TO) : int'($urandom_range(1, TO));
                sel     = int'($urandom_range(0, 3));
                a_div[i] = (sel == 0) ? DW'(dmin) : (sel == 1) ? DW'(dmax) : DW'($urandom_range(0, 24));
            end
            run_training("rnd");
            back_to_idle("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
